// File: rtl/crc16_pkg.sv
// Shared constants and state encoding for the CRC-16 (reflected 0x8408) lane accumulator.
package crc16_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC16_SEED      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } crc16_state_t;

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC-16 update, LSB-first, reflected polynomial.
module crc16_byte_step
    import crc16_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ {8'h00, data_in};
        for (int b = 0; b < 8; b++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC16_POLY_REFL) : (crc_work >> 1);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/crc16_lane_acc.sv
// Multi-byte-lane CRC-16 packet accumulator with saturating byte counter.
// Optional receive checker (crc_rx / crc_err) built only when CRC16_LANE_ACC_CHECK_EN is defined.
module crc16_lane_acc
    import crc16_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    input  logic                    sop,
    input  logic                    eop,
    input  logic [8*DATA_BYTES-1:0] din,
    input  logic [DATA_BYTES-1:0]   din_be,
    output logic [15:0]             crc_out,
    output logic                    crc_valid,
    output logic [CNT_W-1:0]        byte_cnt,
    output logic                    busy,
    output logic                    pkt_abort
`ifdef CRC16_LANE_ACC_CHECK_EN
    ,
    input  logic [15:0]             crc_rx,
    output logic                    crc_err
`endif
);

    crc16_state_t     state_reg;
    logic [15:0]      crc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [15:0]      crc_out_reg;
    logic             crc_valid_reg;
    logic [CNT_W-1:0] byte_cnt_reg;
    logic             busy_reg;
    logic             pkt_abort_reg;

    logic             beat_take;
    logic [15:0]      crc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [15:0]      crc_next;
    logic [CNT_W:0]   beat_bytes;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    logic [15:0] stage   [0:DATA_BYTES];
    logic [15:0] step_out[0:DATA_BYTES-1];

    // Beats outside a packet are only taken when they open a new one.
    assign beat_take = din_valid & (sop | (state_reg == ACC));
    assign crc_base  = sop ? CRC16_SEED : crc_reg;
    assign cnt_base  = sop ? '0 : cnt_reg;

    assign stage[0] = crc_base;

    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            crc16_byte_step u_step (
                .crc_in  (stage[gi]),
                .data_in (din[8*gi +: 8]),
                .crc_out (step_out[gi])
            );
            // Disabled lanes pass the CRC through; enables are contiguous from lane 0.
            assign stage[gi+1] = din_be[gi] ? step_out[gi] : stage[gi];
        end
    endgenerate

    assign crc_next = stage[DATA_BYTES];

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            beat_bytes = beat_bytes + {{CNT_W{1'b0}}, din_be[i]};
        end
        cnt_sum  = {1'b0, cnt_base} + beat_bytes;
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

`ifdef CRC16_LANE_ACC_CHECK_EN
    logic crc_err_reg;
    assign crc_err = crc_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            crc_reg       <= CRC16_SEED;
            cnt_reg       <= '0;
            crc_out_reg   <= 16'h0000;
            crc_valid_reg <= 1'b0;
            byte_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            pkt_abort_reg <= 1'b0;
`ifdef CRC16_LANE_ACC_CHECK_EN
            crc_err_reg   <= 1'b0;
`endif
        end else begin
            crc_valid_reg <= 1'b0;
            pkt_abort_reg <= 1'b0;
`ifdef CRC16_LANE_ACC_CHECK_EN
            crc_err_reg   <= 1'b0;
`endif
            if (beat_take) begin
                crc_reg <= crc_next;
                cnt_reg <= cnt_next;
                if (sop && (state_reg == ACC)) begin
                    pkt_abort_reg <= 1'b1;
                end
                if (eop) begin
                    state_reg     <= DONE;
                    busy_reg      <= 1'b0;
                    crc_valid_reg <= 1'b1;
                    crc_out_reg   <= crc_next;
                    byte_cnt_reg  <= cnt_next;
`ifdef CRC16_LANE_ACC_CHECK_EN
                    crc_err_reg   <= (crc_rx != crc_next);
`endif
                end else begin
                    state_reg <= ACC;
                    busy_reg  <= 1'b1;
                end
            end else if (state_reg == DONE) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end
        end
    end

    assign crc_out   = crc_out_reg;
    assign crc_valid = crc_valid_reg;
    assign byte_cnt  = byte_cnt_reg;
    assign busy      = busy_reg;
    assign pkt_abort = pkt_abort_reg;

endmodule

// File: tb/tb_crc16_lane_acc.sv
// Directed bench for crc16_lane_acc at 1, 2 and 4 byte lanes (the 2-lane copy has a 4-bit counter).
// Checker scenarios are compiled when CRC16_LANE_ACC_CHECK_EN is defined.
module tb_crc16_lane_acc;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        v[3];
    logic        sop_a[3];
    logic        eop_a[3];
    logic [7:0]  din0;
    logic [15:0] din1;
    logic [31:0] din2;
    logic [0:0]  be0;
    logic [1:0]  be1;
    logic [3:0]  be2;
    logic [15:0] crc_o[3];
    logic        cv[3];
    logic        bz[3];
    logic        pa[3];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;
`ifdef CRC16_LANE_ACC_CHECK_EN
    logic [15:0] crc_rx_a[3];
    logic        ce[3];
    logic        last_err[3];
    int          err_seen[3];
`endif

    crc16_lane_acc #(.DATA_BYTES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rstn(rstn), .din_valid(v[0]), .sop(sop_a[0]), .eop(eop_a[0]),
        .din(din0), .din_be(be0), .crc_out(crc_o[0]), .crc_valid(cv[0]),
        .byte_cnt(cnt0), .busy(bz[0]), .pkt_abort(pa[0])
`ifdef CRC16_LANE_ACC_CHECK_EN
        , .crc_rx(crc_rx_a[0]), .crc_err(ce[0])
`endif
    );

    crc16_lane_acc #(.DATA_BYTES(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rstn(rstn), .din_valid(v[1]), .sop(sop_a[1]), .eop(eop_a[1]),
        .din(din1), .din_be(be1), .crc_out(crc_o[1]), .crc_valid(cv[1]),
        .byte_cnt(cnt1), .busy(bz[1]), .pkt_abort(pa[1])
`ifdef CRC16_LANE_ACC_CHECK_EN
        , .crc_rx(crc_rx_a[1]), .crc_err(ce[1])
`endif
    );

    crc16_lane_acc #(.DATA_BYTES(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rstn(rstn), .din_valid(v[2]), .sop(sop_a[2]), .eop(eop_a[2]),
        .din(din2), .din_be(be2), .crc_out(crc_o[2]), .crc_valid(cv[2]),
        .byte_cnt(cnt2), .busy(bz[2]), .pkt_abort(pa[2])
`ifdef CRC16_LANE_ACC_CHECK_EN
        , .crc_rx(crc_rx_a[2]), .crc_err(ce[2])
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_seen[3];
    int          abort_seen[3];
    int          last_lat[3];
    int          eop_cyc[3];
    logic [15:0] last_crc[3];
    logic [15:0] prev_crc[3];
    logic [15:0] last_cnt[3];
    logic        last_busy[3];
    logic [7:0]  pkt_b[32];
    int          pkt_len;

    task automatic sample(input int k);
        logic [15:0] c;
        case (k)
            0:       c = cnt0;
            1:       c = {12'h000, cnt1};
            default: c = cnt2;
        endcase
        last_busy[k] = bz[k];
        if (pa[k]) abort_seen[k]++;
        if (cv[k]) begin
            valid_seen[k]++;
            prev_crc[k] = last_crc[k];
            last_crc[k] = crc_o[k];
            last_cnt[k] = c;
            last_lat[k] = cyc - eop_cyc[k];
`ifdef CRC16_LANE_ACC_CHECK_EN
            last_err[k] = ce[k];
`endif
        end
`ifdef CRC16_LANE_ACC_CHECK_EN
        if (ce[k]) err_seen[k]++;
`endif
    endtask

    task automatic clear(input int k);
        valid_seen[k] = 0;
        abort_seen[k] = 0;
        last_lat[k]   = 0;
        last_crc[k]   = 16'h0;
        prev_crc[k]   = 16'h0;
        last_cnt[k]   = 16'h0;
`ifdef CRC16_LANE_ACC_CHECK_EN
        last_err[k]   = 1'b0;
        err_seen[k]   = 0;
`endif
    endtask

    task automatic drive_beat(input int k, input logic s, input logic e,
                              input logic [31:0] w, input logic [3:0] be);
        @(negedge clk);
        sample(k);
        v[k] = 1'b1;
        sop_a[k] = s;
        eop_a[k] = e;
        case (k)
            0:       begin din0 = w[7:0];  be0 = be[0:0]; end
            1:       begin din1 = w[15:0]; be1 = be[1:0]; end
            default: begin din2 = w;       be2 = be;      end
        endcase
        if (e) eop_cyc[k] = cyc;
    endtask

    task automatic idle_cycle(input int k);
        @(negedge clk);
        sample(k);
        v[k] = 1'b0;
        sop_a[k] = 1'b0;
        eop_a[k] = 1'b0;
    endtask

    task automatic send_pkt(input int k, input int lanes, input int gap);
        if (pkt_len == 0) begin
            drive_beat(k, 1'b1, 1'b1, 32'h0, 4'h0);
        end else begin
            for (int off = 0; off < pkt_len; off += lanes) begin
                logic [31:0] w;
                logic [3:0]  be;
                w = 32'h0;
                be = 4'h0;
                for (int j = 0; j < lanes; j++) begin
                    if (off + j < pkt_len) begin
                        w[8*j +: 8] = pkt_b[off + j];
                        be[j] = 1'b1;
                    end
                end
                drive_beat(k, off == 0, off + lanes >= pkt_len, w, be);
                if (off + lanes < pkt_len)
                    for (int g = 0; g < gap; g++) idle_cycle(k);
            end
        end
        for (int i = 0; i < 3; i++) idle_cycle(k);
    endtask

    task automatic load_check();
        string s;
        s = "123456789";
        for (int i = 0; i < 9; i++) pkt_b[i] = s[i];
        pkt_len = 9;
    endtask

    task automatic load_csi();
        logic [7:0] t[24];
        t = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 24; i++) pkt_b[i] = t[i];
        pkt_len = 24;
    endtask

    task automatic test_reset();
        logic [15:0] c;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       c = cnt0;
                1:       c = {12'h000, cnt1};
                default: c = cnt2;
            endcase
            n_cmp++; if (crc_o[k] !== 16'h0000) begin n_bad++; $display("FAIL reset_crc_out dut%0d got %h want 0000", k, crc_o[k]); end
            n_cmp++; if (cv[k] !== 1'b0) begin n_bad++; $display("FAIL reset_crc_valid dut%0d got %b want 0", k, cv[k]); end
            n_cmp++; if (c !== 16'h0000) begin n_bad++; $display("FAIL reset_byte_cnt dut%0d got %0d want 0", k, c); end
            n_cmp++; if (bz[k] !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d got %b want 0", k, bz[k]); end
            n_cmp++; if (pa[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_abort dut%0d got %b want 0", k, pa[k]); end
        end
        rstn = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_check_string(input int k, input int lanes);
        clear(k);
        load_check();
        send_pkt(k, lanes, 0);
        n_cmp++; if (valid_seen[k] !== 1) begin n_bad++; $display("FAIL check_valid_count dut%0d got %0d want 1", k, valid_seen[k]); end
        n_cmp++; if (last_crc[k] !== 16'h6F91) begin n_bad++; $display("FAIL check_crc dut%0d got %h want 6f91", k, last_crc[k]); end
        n_cmp++; if (last_cnt[k] !== 16'd9) begin n_bad++; $display("FAIL check_cnt dut%0d got %0d want 9", k, last_cnt[k]); end
        n_cmp++; if (last_lat[k] !== 1) begin n_bad++; $display("FAIL check_latency dut%0d got %0d want 1", k, last_lat[k]); end
        $display("test_check_string dut%0d lanes=%0d crc=%h cnt=%0d", k, lanes, last_crc[k], last_cnt[k]);
    endtask

    task automatic test_csi2();
        logic [15:0] want_cnt;
        for (int k = 0; k < 3; k++) begin
            clear(k);
            load_csi();
            send_pkt(k, 1 << k, 0);
            want_cnt = (k == 1) ? 16'd15 : 16'd24;
            n_cmp++; if (valid_seen[k] !== 1) begin n_bad++; $display("FAIL csi_valid_count dut%0d got %0d want 1", k, valid_seen[k]); end
            n_cmp++; if (last_crc[k] !== 16'h00F0) begin n_bad++; $display("FAIL csi_crc dut%0d got %h want 00f0", k, last_crc[k]); end
            n_cmp++; if (last_cnt[k] !== want_cnt) begin n_bad++; $display("FAIL csi_cnt dut%0d got %0d want %0d", k, last_cnt[k], want_cnt); end
            $display("test_csi2 dut%0d crc=%h cnt=%0d", k, last_crc[k], last_cnt[k]);
        end
    endtask

    task automatic test_empty();
        for (int k = 0; k < 3; k += 2) begin
            clear(k);
            pkt_len = 0;
            send_pkt(k, 1, 0);
            n_cmp++; if (valid_seen[k] !== 1) begin n_bad++; $display("FAIL empty_valid_count dut%0d got %0d want 1", k, valid_seen[k]); end
            n_cmp++; if (last_crc[k] !== 16'hFFFF) begin n_bad++; $display("FAIL empty_crc dut%0d got %h want ffff", k, last_crc[k]); end
            n_cmp++; if (last_cnt[k] !== 16'd0) begin n_bad++; $display("FAIL empty_cnt dut%0d got %0d want 0", k, last_cnt[k]); end
            $display("test_empty dut%0d crc=%h cnt=%0d", k, last_crc[k], last_cnt[k]);
        end
    endtask

    task automatic test_hold_gaps();
        clear(1);
        load_check();
        send_pkt(1, 2, 3);
        n_cmp++; if (last_crc[1] !== 16'h6F91) begin n_bad++; $display("FAIL gap_crc got %h want 6f91", last_crc[1]); end
        n_cmp++; if (last_cnt[1] !== 16'd9) begin n_bad++; $display("FAIL gap_cnt got %0d want 9", last_cnt[1]); end
        $display("test_hold_gaps crc=%h cnt=%0d", last_crc[1], last_cnt[1]);
    endtask

    task automatic test_ignore_idle();
        clear(2);
        drive_beat(2, 1'b0, 1'b0, 32'h11223344, 4'hF);
        drive_beat(2, 1'b0, 1'b1, 32'h55667788, 4'hF);
        for (int i = 0; i < 3; i++) idle_cycle(2);
        n_cmp++; if (valid_seen[2] !== 0) begin n_bad++; $display("FAIL ignore_valid_count got %0d want 0", valid_seen[2]); end
        n_cmp++; if (last_busy[2] !== 1'b0) begin n_bad++; $display("FAIL ignore_busy got %b want 0", last_busy[2]); end
        $display("test_ignore_idle valid_seen=%0d", valid_seen[2]);
    endtask

    task automatic test_restart();
        clear(0);
        drive_beat(0, 1'b1, 1'b0, 32'h55, 4'h1);
        drive_beat(0, 1'b0, 1'b0, 32'hAA, 4'h1);
        load_check();
        send_pkt(0, 1, 0);
        n_cmp++; if (abort_seen[0] !== 1) begin n_bad++; $display("FAIL restart_abort_count got %0d want 1", abort_seen[0]); end
        n_cmp++; if (valid_seen[0] !== 1) begin n_bad++; $display("FAIL restart_valid_count got %0d want 1", valid_seen[0]); end
        n_cmp++; if (last_crc[0] !== 16'h6F91) begin n_bad++; $display("FAIL restart_crc got %h want 6f91", last_crc[0]); end
        n_cmp++; if (last_cnt[0] !== 16'd9) begin n_bad++; $display("FAIL restart_cnt got %0d want 9", last_cnt[0]); end
        $display("test_restart aborts=%0d crc=%h", abort_seen[0], last_crc[0]);
    endtask

    task automatic test_back_to_back();
        clear(2);
        load_csi();
        for (int off = 0; off < 24; off += 4)
            drive_beat(2, off == 0, off == 20,
                       {pkt_b[off+3], pkt_b[off+2], pkt_b[off+1], pkt_b[off]}, 4'hF);
        load_check();
        send_pkt(2, 4, 0);
        n_cmp++; if (valid_seen[2] !== 2) begin n_bad++; $display("FAIL b2b_valid_count got %0d want 2", valid_seen[2]); end
        n_cmp++; if (prev_crc[2] !== 16'h00F0) begin n_bad++; $display("FAIL b2b_first_crc got %h want 00f0", prev_crc[2]); end
        n_cmp++; if (last_crc[2] !== 16'h6F91) begin n_bad++; $display("FAIL b2b_second_crc got %h want 6f91", last_crc[2]); end
        n_cmp++; if (last_cnt[2] !== 16'd9) begin n_bad++; $display("FAIL b2b_second_cnt got %0d want 9", last_cnt[2]); end
        $display("test_back_to_back crc1=%h crc2=%h", prev_crc[2], last_crc[2]);
    endtask

    task automatic test_reset_mid();
        clear(1);
        drive_beat(1, 1'b1, 1'b0, 32'h3231, 4'h3);
        drive_beat(1, 1'b0, 1'b0, 32'h3433, 4'h3);
        @(negedge clk);
        sample(1);
        n_cmp++; if (last_busy[1] !== 1'b1) begin n_bad++; $display("FAIL midreset_busy_before got %b want 1", last_busy[1]); end
        rstn = 1'b0;
        v[1] = 1'b0;
        @(negedge clk);
        sample(1);
        rstn = 1'b1;
        drive_beat(1, 1'b0, 1'b1, 32'h3635, 4'h3);
        for (int i = 0; i < 3; i++) idle_cycle(1);
        n_cmp++; if (valid_seen[1] !== 0) begin n_bad++; $display("FAIL midreset_valid_count got %0d want 0", valid_seen[1]); end
        n_cmp++; if (abort_seen[1] !== 0) begin n_bad++; $display("FAIL midreset_abort_count got %0d want 0", abort_seen[1]); end
        n_cmp++; if (last_busy[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_busy_after got %b want 0", last_busy[1]); end
        $display("test_reset_mid valid_seen=%0d", valid_seen[1]);
    endtask

`ifdef CRC16_LANE_ACC_CHECK_EN
    task automatic test_checker();
        clear(0);
        crc_rx_a[0] = 16'h6F91;
        load_check();
        send_pkt(0, 1, 0);
        n_cmp++; if (last_err[0] !== 1'b0) begin n_bad++; $display("FAIL checker_good_err got %b want 0", last_err[0]); end
        n_cmp++; if (err_seen[0] !== 0) begin n_bad++; $display("FAIL checker_good_err_count got %0d want 0", err_seen[0]); end
        clear(0);
        crc_rx_a[0] = 16'h6F90;
        send_pkt(0, 1, 0);
        n_cmp++; if (last_err[0] !== 1'b1) begin n_bad++; $display("FAIL checker_bad_err got %b want 1", last_err[0]); end
        n_cmp++; if (err_seen[0] !== 1) begin n_bad++; $display("FAIL checker_bad_err_count got %0d want 1", err_seen[0]); end
        $display("test_checker err_pulses=%0d", err_seen[0]);
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0;
            sop_a[k] = 1'b0;
            eop_a[k] = 1'b0;
            eop_cyc[k] = 0;
            last_busy[k] = 1'b0;
            clear(k);
`ifdef CRC16_LANE_ACC_CHECK_EN
            crc_rx_a[k] = 16'h0000;
`endif
        end
        din0 = 8'h0;
        din1 = 16'h0;
        din2 = 32'h0;
        be0 = 1'b0;
        be1 = 2'b0;
        be2 = 4'b0;
        pkt_len = 0;

        test_reset();
        test_check_string(0, 1);
        test_check_string(2, 4);
        test_csi2();
        test_empty();
        test_hold_gaps();
        test_ignore_idle();
        test_restart();
        test_back_to_back();
        test_reset_mid();
`ifdef CRC16_LANE_ACC_CHECK_EN
        test_checker();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
